// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-style controller:
// state enum, opcodes, datapath mux encodings and the per-state control decode.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore decode; the FETCH ready-qualified strobes are added in the top.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_known(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: state register, next-state logic and a
// registered Moore output decoder, with optional memory-ready handshaking.
//
// state  | meaning
// IDLE   | post-reset, all controls off
// FETCH  | read instruction at PC, PC+4 on ready
// DECODE | register read, branch target precompute
// MEMADR | load/store address computation
// MEMRD  | data memory read, held until ready
// MEMWB  | write loaded data to rt
// MEMWR  | data memory write, held until ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | beq compare, conditional PC load
// JUMP   | unconditional PC load from jump target
module multicycle_controller #(
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);
    import mips_ctrl_pkg::*;

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   ready;
    logic   in_fetch;

    assign ready    = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign in_fetch = (state_q == S_FETCH);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            // Anything other than a store is treated as a read: reads have no side effect.
            S_MEMADR: state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (ready) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            ctrl_q    <= state_ctrl(state_nxt);
            illegal_q <= (state_q == S_DECODE) && !op_known(Op);
        end
    end

    // IR load and PC+4 fire only on the accepting FETCH cycle.
    assign IRWrite     = in_fetch & ready;
    assign PCWrite     = ctrl_q.pc_write | (in_fetch & ready);
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.i_or_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign illegal_op  = illegal_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instruction
// streams checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n, mem_ready;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    logic       rst_n2, zero_ready;
    logic [5:0] Op2;
    logic       h_PCWrite, h_PCWriteCond, h_IorD, h_MemRead, h_MemWrite, h_IRWrite;
    logic       h_MemtoReg, h_RegDst, h_RegWrite, h_ALUSrcA, h_illegal_op;
    logic [1:0] h_ALUSrcB, h_ALUOp, h_PCSource;
    logic [3:0] h_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit pend_ill = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    multicycle_controller #(.MEM_HANDSHAKE(0)) dut_nohs (
        .clk(clk), .rst_n(rst_n2), .Op(Op2), .mem_ready(zero_ready),
        .PCWrite(h_PCWrite), .PCWriteCond(h_PCWriteCond), .IorD(h_IorD), .MemRead(h_MemRead),
        .MemWrite(h_MemWrite), .IRWrite(h_IRWrite), .MemtoReg(h_MemtoReg), .RegDst(h_RegDst),
        .RegWrite(h_RegWrite), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp),
        .PCSource(h_PCSource), .illegal_op(h_illegal_op), .state(h_state)
    );

    // Expected control word per state number, straight from the output table.
    function automatic logic [16:0] exp_vec(int st, bit rdy, bit ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            2:  srcb = 2'b11;
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin srca = 1; aluop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            10: begin pcw = 1; pcsrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
    endfunction

    task automatic check(input int st, input bit rdy, input bit ill, input string tag);
        logic [16:0] obs, exp;
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
        exp = exp_vec(st, rdy, ill);
        n_cmp++;
        assert (state === 4'(st)) else begin
            n_bad++;
            $error("FAIL %s.state: observed %0d expected %0d", tag, state, st);
        end
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.ctrl(st=%0d): observed %05h expected %05h", tag, st, obs, exp);
        end
    endtask

    task automatic cyc(input int st, input bit rdy, input logic [5:0] op, input bit ill,
                       input string tag);
        @(negedge clk);
        mem_ready = rdy;
        Op = op;
        #1 check(st, rdy, ill, tag);
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // One instruction from FETCH entry; fwait/mwait = not-ready cycles in FETCH / memory state.
    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input string tag);
        for (int i = 0; i <= fwait; i++)
            cyc(1, i == fwait, rop(), pend_ill && i == 0, tag);
        pend_ill = 0;
        cyc(2, 1'($urandom), op, 0, tag);
        case (op)
            T_LW: begin
                cyc(3, 1'($urandom), op, 0, tag);
                for (int i = 0; i <= mwait; i++) cyc(4, i == mwait, rop(), 0, tag);
                cyc(5, 1'($urandom), rop(), 0, tag);
            end
            T_SW: begin
                cyc(3, 1'($urandom), op, 0, tag);
                for (int i = 0; i <= mwait; i++) cyc(6, i == mwait, rop(), 0, tag);
            end
            T_R: begin
                cyc(7, 1'($urandom), rop(), 0, tag);
                cyc(8, 1'($urandom), rop(), 0, tag);
            end
            T_BEQ: cyc(9, 1'($urandom), rop(), 0, tag);
            T_J:   cyc(10, 1'($urandom), rop(), 0, tag);
            default: pend_ill = 1;
        endcase
    endtask

    task automatic check_nohs(input int st, input bit irw, input bit rw, input string tag);
        @(negedge clk);
        #1;
        n_cmp++;
        assert ({h_state, h_IRWrite, h_RegWrite} === {4'(st), irw, rw}) else begin
            n_bad++;
            $error("FAIL %s: observed st=%0d irw=%0b rw=%0b expected st=%0d irw=%0b rw=%0b",
                   tag, h_state, h_IRWrite, h_RegWrite, st, irw, rw);
        end
    endtask

    initial begin
        logic [5:0] ops [5] = '{T_R, T_LW, T_SW, T_BEQ, T_J};
        logic [5:0] op;
        rst_n = 0; rst_n2 = 0; mem_ready = 0; zero_ready = 0; Op = '0; Op2 = T_R;

        cyc(0, 1, rop(), 0, "reset");
        cyc(0, 0, rop(), 0, "reset");
        @(negedge clk); rst_n = 1; #1 check(0, 0, 0, "idle_after_reset");

        run_instr(T_LW, 0, 0, "lw_ready");
        run_instr(T_SW, 0, 3, "sw_wait3");
        run_instr(T_BEQ, 0, 0, "beq");
        run_instr(T_J, 0, 0, "j");
        run_instr(6'h3F, 0, 0, "illegal_3f");
        run_instr(T_R, 2, 0, "r_fetchwait");
        run_instr(T_LW, 1, 2, "lw_waits");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = rop(); while (op == T_R || op == T_LW || op == T_SW ||
                                      op == T_BEQ || op == T_J);
            end else begin
                op = ops[$urandom_range(0, 4)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end

        // Reset in EXEC: controls clear at once, no ALUWB afterwards.
        cyc(1, 1, rop(), pend_ill, "rst_exec");
        pend_ill = 0;
        cyc(2, 1, T_R, 0, "rst_exec");
        cyc(7, 1, rop(), 0, "rst_exec");
        #2 rst_n = 0;
        #1 check(0, 0, 0, "rst_exec_immediate");
        cyc(0, 1, rop(), 0, "rst_exec_hold");
        cyc(0, 1, rop(), 0, "rst_exec_hold");
        @(negedge clk); rst_n = 1; #1 check(0, 0, 0, "rst_exec_idle");
        run_instr(T_SW, 0, 1, "after_rst");

        // No-handshake instance with mem_ready tied low: R-type in 4 cycles.
        @(negedge clk); rst_n2 = 1;
        #1;
        n_cmp++;
        assert (h_state === 4'd0) else begin
            n_bad++;
            $error("FAIL nohs_idle: observed %0d expected 0", h_state);
        end
        check_nohs(1, 1, 0, "nohs_fetch");
        check_nohs(2, 0, 0, "nohs_decode");
        check_nohs(7, 0, 0, "nohs_exec");
        check_nohs(8, 0, 1, "nohs_aluwb");
        check_nohs(1, 1, 0, "nohs_refetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1: 1 means memory states wait for mem_ready; 0 means mem_ready is ignored and treated as 1.
REQ-002 The block SHALL have these ports, one per line below:
- clk  in  1  single clock for the block, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Op  in  6  opcode field of the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write-data select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- state  out  4  current state encoding, for debug.

Function
REQ-003 The block SHALL use a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10.
REQ-004 The block SHALL decode opcodes as follows: R=000000, lw=100011, sw=101011, beq=000100, j=000010.
REQ-005 Transitions SHALL be: IDLE->FETCH; FETCH->DECODE on ready; DECODE->MEMADR for lw/sw, EXEC for R, BRANCH for beq, JUMP for j, FETCH otherwise; MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB on ready; MEMWR->FETCH on ready; EXEC->ALUWB; MEMWB, ALUWB, BRANCH and JUMP->FETCH. "ready" is mem_ready, or 1 when MEM_HANDSHAKE=0.
REQ-006 In FETCH the block SHALL hold MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00 every cycle; it SHALL assert IRWrite=1 and PCWrite=1 only in the cycle where ready=1.
REQ-007 In DECODE the block SHALL output ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-008 In MEMADR the block SHALL output ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-009 In MEMRD the block SHALL output MemRead=1, IorD=1. In MEMWR it SHALL output MemWrite=1, IorD=1. Both SHALL be held until ready.
REQ-010 In MEMWB the block SHALL output RegWrite=1, MemtoReg=1, RegDst=0.
REQ-011 In EXEC the block SHALL output ALUSrcA=1, ALUSrcB=00, ALUOp=10. In ALUWB it SHALL output RegWrite=1, RegDst=1, MemtoReg=0.
REQ-012 In BRANCH the block SHALL output ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-013 In JUMP the block SHALL output PCWrite=1, PCSource=10.
REQ-014 Any output not listed for a state SHALL be 0 in that state; IDLE SHALL drive all outputs 0.
REQ-015 The block SHALL pulse illegal_op for exactly one cycle: the first FETCH cycle following a DECODE that saw an unknown Op.
REQ-016 Op SHALL be sampled only in DECODE and MEMADR; changes of Op in other states SHALL have no effect.
REQ-017 Instruction latency with ready always 1 SHALL be: lw 5 cycles, sw 4, R 4, beq 3, j 3, illegal 2, each counted from FETCH entry.

Reset
REQ-018 When rst_n is low, state SHALL go to IDLE asynchronously, all control outputs SHALL be 0 and illegal_op SHALL be 0.
REQ-019 Reset asserted mid-instruction SHALL abandon the instruction; no RegWrite, MemWrite or PCWrite SHALL occur after rst_n falls.
REQ-020 After rst_n rises, the block SHALL spend exactly one cycle in IDLE before entering FETCH.

Structure
REQ-021 The state enum, the opcode constants, and the ALUOp/ALUSrcB/PCSource encodings SHALL live in a shared package mips_ctrl_pkg.
REQ-022 The block SHALL consist of one state register, next-state logic and an output decoder; there SHALL be no sub-module.

Verification
REQ-023 lw with mem_ready=1 -> states 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 in cycle 5 only.
REQ-024 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, then FETCH.
REQ-025 beq -> cycle 3 shows PCWriteCond=1, ALUOp=01, PCSource=01. j -> cycle 3 shows PCWrite=1, PCSource=10.
REQ-026 Op=111111 -> DECODE->FETCH; illegal_op=1 for one cycle; no write enables asserted.
REQ-027 rst_n pulled low during EXEC -> all outputs 0 immediately; after release, one IDLE cycle, then FETCH; no ALUWB occurs.
REQ-028 MEM_HANDSHAKE=0 with mem_ready tied 0 -> R-type completes in 4 cycles.
